// File: rtl/wash_seq_pkg.sv
// Shared encodings for the wash-program sequencer: step states, phase and sub-step bit indices.
package wash_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_AGIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_SPIN  = 3'd4,
        S_DRY   = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    localparam int PH_DRY = 2;
    localparam int PH_RIN = 1;
    localparam int PH_WAS = 0;

    localparam int SS_FIL = 2;
    localparam int SS_SPI = 1;
    localparam int SS_DRA = 0;

    // The lowest pending bit is always the phase currently running.
    function automatic logic [2:0] lowest_bit(input logic [2:0] m);
        return m & (~m + 3'd1);
    endfunction

    function automatic state_t first_step(input logic [2:0] m);
        if (m[PH_WAS] || m[PH_RIN]) return S_FILL;
        if (m[PH_DRY])              return S_DRY;
        return S_FIN;
    endfunction

endpackage

// File: rtl/wash_tick.sv
// Timebase prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module wash_tick #(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic freeze,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !freeze && (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (!freeze)
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wash_seq.sv
// Wash-program sequencer: runs wash/rinse/dry phases and drives panel LED requests.
// Define WASH_DOOR_LOCK_EN to add the door_open interlock.
//
// state   | meaning
// IDLE    | never started since reset
// FILL    | wash/rinse water fill
// AGIT    | wash/rinse agitate
// DRAIN   | wash/rinse drain
// SPIN    | wash/rinse spin, ends the phase
// DRY     | dry phase
// FIN     | program complete, done held
module wash_seq
    import wash_seq_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int T_FILL   = 4,
    parameter int T_AGIT   = 8,
    parameter int T_DRAIN  = 3,
    parameter int T_SPIN   = 4,
    parameter int T_DRY    = 10,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] prog,
    input  logic       start,
    input  logic       pause,
`ifdef WASH_DOOR_LOCK_EN
    input  logic       door_open,
`endif
    output logic [2:0] ld_drw,
    output logic [2:0] fl_drw,
    output logic [2:0] ld_fsd,
    output logic       busy,
    output logic       done
);

    state_t           state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             paused_q, paused_d;
    logic [2:0]       ld_drw_q, ld_drw_d, fl_drw_q, fl_drw_d, ld_fsd_q, ld_fsd_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             busy_now, door, start_ok, step_new, tick;
    logic [2:0]       cur;

    function automatic logic [CNT_W-1:0] t_load(input state_t s);
        case (s)
            S_FILL:  return CNT_W'(T_FILL - 1);
            S_AGIT:  return CNT_W'(T_AGIT - 1);
            S_DRAIN: return CNT_W'(T_DRAIN - 1);
            S_SPIN:  return CNT_W'(T_SPIN - 1);
            S_DRY:   return CNT_W'(T_DRY - 1);
            default: return '0;
        endcase
    endfunction

`ifdef WASH_DOOR_LOCK_EN
    assign door = door_open;
`else
    assign door = 1'b0;
`endif

    assign busy_now = (state_q != S_IDLE) && (state_q != S_FIN);
    assign start_ok = start && (prog != 3'b000) && !busy_now && !door;

    wash_tick #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (step_new),
        .freeze (paused_q || !busy_now),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        step_d   = step_q;
        paused_d = paused_q;
        step_new = 1'b0;
        if (start_ok) begin
            pend_d   = prog;
            state_d  = first_step(prog);
            paused_d = 1'b0;
            step_new = 1'b1;
        end else if (busy_now) begin
            // An open door blocks resume and forces a pause.
            if (pause && !(paused_q && door)) paused_d = !paused_q;
            if (door && !paused_q)            paused_d = 1'b1;
            if (tick) begin
                if (step_q == '0) begin
                    step_new = 1'b1;
                    case (state_q)
                        S_FILL:  state_d = S_AGIT;
                        S_AGIT:  state_d = S_DRAIN;
                        S_DRAIN: state_d = S_SPIN;
                        S_SPIN: begin
                            pend_d  = pend_q & ~lowest_bit(pend_q);
                            state_d = first_step(pend_d);
                        end
                        S_DRY: begin
                            pend_d  = pend_q & ~(3'b001 << PH_DRY);
                            state_d = S_FIN;
                        end
                        default: state_d = state_q;
                    endcase
                end else begin
                    step_d = step_q - CNT_W'(1);
                end
            end
        end
        if (step_new) step_d = t_load(state_d);
    end

    always_comb begin
        busy_d   = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d   = (state_d == S_FIN);
        cur      = busy_d ? lowest_bit(pend_d) : 3'b000;
        fl_drw_d = cur;
        ld_drw_d = busy_d ? (pend_d & ~cur) : 3'b000;
        ld_fsd_d = 3'b000;
        if (!paused_d) begin
            case (state_d)
                S_FILL:                 ld_fsd_d[SS_FIL] = 1'b1;
                S_AGIT, S_SPIN, S_DRY:  ld_fsd_d[SS_SPI] = 1'b1;
                S_DRAIN:                ld_fsd_d[SS_DRA] = 1'b1;
                default:                ld_fsd_d = 3'b000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            step_q   <= '0;
            paused_q <= 1'b0;
            ld_drw_q <= '0;
            fl_drw_q <= '0;
            ld_fsd_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            step_q   <= step_d;
            paused_q <= paused_d;
            ld_drw_q <= ld_drw_d;
            fl_drw_q <= fl_drw_d;
            ld_fsd_q <= ld_fsd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ld_drw = ld_drw_q;
    assign fl_drw = fl_drw_q;
    assign ld_fsd = ld_fsd_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
